vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Tile-map video RAM with a built-in arbiter that shares a single-port 40×30×8-bit RAM between two requesters: the VGA scan-out, which fetches one tile per pixel tick, and the PicoBlaze port bus, which reads and writes tiles.

- Sits between `kcpsm3` port signals, `vga_sync` (`ptick`, `x_div`, `y_div`) and the RGB output register.
- Scan-out always wins.
- PicoBlaze accesses are queued as one-deep requests and executed in free cycles.

## Interface
Parameters:
- `COLS`, default 40: tiles per row; valid `x` is 0..COLS-1.
- `ROWS`, default 30: tile rows; valid `y` is 0..ROWS-1.
- `BASE_PORT`, default 8'hF0: first of five consecutive port IDs owned by this block.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `ptick` in 1: pixel tick; a cycle with `ptick`=1 is a scan-out slot.
- `x_div` in 6: scan tile column.
- `y_div` in 6: scan tile row.
- `pico_addr` in 8: PicoBlaze `port_id`.
- `pico_data_in` in 8: PicoBlaze `out_port`.
- `pico_write_strobe` in 1: PicoBlaze write strobe.
- `pico_read_strobe` in 1: PicoBlaze read strobe.
- `pico_data_out` out 8: combinational register read mux, selected by `pico_addr`.
- `vga_out` out 8: registered tile colour for the scan-out.
- `busy` out 1: a PicoBlaze request is pending or executing.

## Operation
Port map, offsets from `BASE_PORT`:
- +0 X: write/read the X register. Writable while busy.
- +1 Y: write/read the Y register. Writable while busy.
- +2 DATA:
  - Write with value d: captures `{Y*COLS+X, d}` and requests a RAM write.
  - Read: returns the RDATA register; a read strobe here clears `rd_valid`.
- +3 CMD/STAT:
  - Write any value: captures `Y*COLS+X` and requests a RAM read.
  - Read: returns `{6'b0, busy, rd_valid}`.
- +4 FILL: only with `VRAM_FILL_EN`; see Configuration.
- Any other `pico_addr`: `pico_data_out` = 0.

Request rules:
- Writes to +2, +3 or +4 while `busy` is high are dropped without side effect.
- A new request clears `rd_valid`.
- Address is computed at capture with full-width arithmetic (11-bit result).
- If X ≥ COLS or Y ≥ ROWS at capture:
  - a write request completes without touching RAM;
  - a read request returns RDATA = 0.

FSM (states IDLE, WR, RD, RDLAT, FILL):
- IDLE → WR, RD or FILL on a captured request; `busy` goes high in the same cycle.
- WR: on the first cycle with `ptick`=0, the RAM write executes, then → IDLE.
- RD: on the first cycle with `ptick`=0, the RAM read is issued, then → RDLAT.
- RDLAT: RDATA is loaded from RAM, `rd_valid` goes to 1, then → IDLE.
- `busy` falls on entering IDLE.

Scan-out:
- In every `ptick`=1 cycle, the RAM reads address `y_div*COLS+x_div`.
- `vga_out` takes that data one cycle later and holds it until the next scan fetch.
- If `x_div` ≥ COLS or `y_div` ≥ ROWS, `vga_out` = 0.
- The RAM port is never driven by the PicoBlaze during a `ptick`=1 cycle.

Reset:
- All outputs 0: `vga_out`=0, `pico_data_out`=0 for mapped ports, `busy`=0.
- X, Y, RDATA and `rd_valid` all 0; state IDLE.
- RAM contents are not reset.
- Reset mid-operation aborts the operation; a pending write that has not yet been granted is lost.

## Timing
- Write latency: capture cycle + wait for the first `ptick`=0 cycle + 1 → `busy` low. Minimum 2 cycles when `ptick` alternates.
- Read latency: capture + first free cycle + 1 (RDLAT) → `rd_valid`. Minimum 3 cycles.
- Scan-out latency: exactly 1 cycle from the `ptick` fetch cycle to `vga_out`.
- Simultaneous read strobe on +2 and a new capture: the capture wins and `rd_valid` ends at 0.
- X/Y writes in the capture cycle do not affect the captured address; the old register value is used.

## Configuration
`VRAM_FILL_EN`:
- Defined:
  - A write of colour c to +4 enters FILL.
  - An 11-bit counter runs 0..COLS*ROWS-1, writing c to one cell per `ptick`=0 cycle; `busy` stays high.
  - Exit to IDLE after cell COLS*ROWS-1 is written.
  - Reset mid-fill leaves the partial contents in RAM.
- Undefined:
  - No fill counter is built.
  - Port +4 is unmapped: writes are ignored, reads return 0.

## Test plan
- Reset, then read +0..+3 → all 0; `busy`=0; `vga_out`=0.
- X=5, Y=2, DATA=8'hE0; then scan with `x_div`=5, `y_div`=2, `ptick`=1 → `vga_out`=8'hE0 one cycle later; `busy` high for ≥2 cycles, never writing during a `ptick`=1 cycle.
- X=5, Y=2, write CMD; poll STAT → 8'h01 after ≤4 cycles; read +2 → 8'hE0; STAT then 8'h00.
- X=40, Y=0: DATA write leaves RAM unchanged (address 40 = (0,1) still holds its old value); a read request returns 0.
- Second DATA write while `busy` → dropped; RAM holds the first value; X writes during busy are accepted.
- With `VRAM_FILL_EN`, FILL=8'h1C, `ptick` alternating → `busy` high ~2400 cycles; cells (0,0) and (39,29) both read 8'h1C. Without `VRAM_FILL_EN`, the same write → `busy` stays 0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Purpose  : Scan-out and PicoBlaze port bus bundle for vram_arbiter.
// Revision : 1.0
// ============================================================================
interface vram_arbiter_if;
  logic       ptick;
  logic [5:0] x_div;
  logic [5:0] y_div;
  logic [7:0] pico_addr;
  logic [7:0] pico_data_in;
  logic       pico_write_strobe;
  logic       pico_read_strobe;
  logic [7:0] pico_data_out;
  logic [7:0] vga_out;
  logic       busy;

  modport master (
    output ptick, x_div, y_div, pico_addr, pico_data_in,
           pico_write_strobe, pico_read_strobe,
    input  pico_data_out, vga_out, busy
  );

  modport slave (
    input  ptick, x_div, y_div, pico_addr, pico_data_in,
           pico_write_strobe, pico_read_strobe,
    output pico_data_out, vga_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port tile RAM shared by VGA scan-out (priority) and a
//            one-deep PicoBlaze request queue. Optional fill: VRAM_FILL_EN.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int         COLS      = 40,
  parameter int         ROWS      = 30,
  parameter logic [7:0] BASE_PORT = 8'hF0
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);
  localparam int         c_AW        = 11;
  localparam int         c_CELLS     = COLS * ROWS;
  localparam logic [7:0] c_PORT_X    = BASE_PORT;
  localparam logic [7:0] c_PORT_Y    = BASE_PORT + 8'd1;
  localparam logic [7:0] c_PORT_DATA = BASE_PORT + 8'd2;
  localparam logic [7:0] c_PORT_CMD  = BASE_PORT + 8'd3;
  localparam logic [7:0] c_COLS8     = 8'(COLS);
  localparam logic [7:0] c_ROWS8     = 8'(ROWS);
  localparam logic [c_AW-1:0] c_COLS_A = c_AW'(COLS);
`ifdef VRAM_FILL_EN
  localparam logic [7:0]      c_PORT_FILL = BASE_PORT + 8'd4;
  localparam logic [c_AW-1:0] c_LAST      = c_AW'(c_CELLS - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDLAT, S_FILL} state_t;
  state_t r_state, w_state_nx;

  logic [7:0]      mem [0:c_CELLS-1];
  logic [7:0]      r_x, r_y, r_rdata, r_req_data, r_ram_q, r_vga;
  logic [c_AW-1:0] r_req_addr;
  logic            r_req_ok, r_rd_valid;
`ifdef VRAM_FILL_EN
  logic [c_AW-1:0] r_fill_cnt;
`endif

  logic            w_idle, w_cap_wr, w_cap_rd, w_cap_fill, w_capture, w_busy;
  logic            w_xy_ok, w_scan_ok, w_ram_we;
  logic [c_AW-1:0] w_cap_addr, w_scan_addr, w_ram_addr;
  logic [7:0]      w_dout;

  assign w_idle   = (r_state == S_IDLE);
  assign w_cap_wr = bus.pico_write_strobe && (bus.pico_addr == c_PORT_DATA) && w_idle;
  assign w_cap_rd = bus.pico_write_strobe && (bus.pico_addr == c_PORT_CMD) && w_idle;
`ifdef VRAM_FILL_EN
  assign w_cap_fill = bus.pico_write_strobe && (bus.pico_addr == c_PORT_FILL) && w_idle;
`else
  assign w_cap_fill = 1'b0;
`endif
  assign w_capture = w_cap_wr | w_cap_rd | w_cap_fill;
  // busy is raised combinationally so the capture cycle already reports it
  assign w_busy    = !w_idle || w_capture;

  assign w_xy_ok     = (r_x < c_COLS8) && (r_y < c_ROWS8);
  assign w_cap_addr  = c_AW'(r_y) * c_COLS_A + c_AW'(r_x);
  assign w_scan_ok   = ({2'b00, bus.x_div} < c_COLS8) && ({2'b00, bus.y_div} < c_ROWS8);
  assign w_scan_addr = c_AW'(bus.y_div) * c_COLS_A + c_AW'(bus.x_div);

  always_comb begin
    w_state_nx = r_state;
    w_ram_we   = 1'b0;
    w_ram_addr = w_scan_ok ? w_scan_addr : '0;
    case (r_state)
      S_IDLE: begin
        if (w_cap_wr)        w_state_nx = S_WR;
        else if (w_cap_rd)   w_state_nx = S_RD;
        else if (w_cap_fill) w_state_nx = S_FILL;
      end
      S_WR: if (!bus.ptick) begin
        w_ram_we   = r_req_ok;
        w_ram_addr = r_req_ok ? r_req_addr : '0;
        w_state_nx = S_IDLE;
      end
      S_RD: if (!bus.ptick) begin
        w_ram_addr = r_req_ok ? r_req_addr : '0;
        w_state_nx = S_RDLAT;
      end
      S_RDLAT: w_state_nx = S_IDLE;
      S_FILL: begin
`ifdef VRAM_FILL_EN
        if (!bus.ptick) begin
          w_ram_we   = 1'b1;
          w_ram_addr = r_fill_cnt;
          if (r_fill_cnt == c_LAST) w_state_nx = S_IDLE;
        end
`else
        w_state_nx = S_IDLE;
`endif
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // RAM contents survive reset; a write is suppressed while rst is asserted
  always_ff @(posedge clk) begin
    if (w_ram_we && !rst) mem[w_ram_addr] <= r_req_data;
    r_ram_q <= mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_req_ok   <= 1'b0;
      r_vga      <= '0;
`ifdef VRAM_FILL_EN
      r_fill_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      if (bus.pico_write_strobe && bus.pico_addr == c_PORT_X) r_x <= bus.pico_data_in;
      if (bus.pico_write_strobe && bus.pico_addr == c_PORT_Y) r_y <= bus.pico_data_in;
      if (w_capture) begin
        r_req_addr <= w_cap_addr;
        r_req_data <= bus.pico_data_in;
        r_req_ok   <= w_cap_fill | w_xy_ok;
      end
      if (w_capture)
        r_rd_valid <= 1'b0;
      else if (r_state == S_RDLAT)
        r_rd_valid <= 1'b1;
      else if (bus.pico_read_strobe && bus.pico_addr == c_PORT_DATA)
        r_rd_valid <= 1'b0;
      if (r_state == S_RDLAT) r_rdata <= r_req_ok ? r_ram_q : 8'h00;
      if (bus.ptick) r_vga <= w_scan_ok ? mem[w_ram_addr] : 8'h00;
`ifdef VRAM_FILL_EN
      if (w_cap_fill)
        r_fill_cnt <= '0;
      else if (r_state == S_FILL && !bus.ptick)
        r_fill_cnt <= r_fill_cnt + 1'b1;
`endif
    end
  end

  always_comb begin
    w_dout = 8'h00;
    if (bus.pico_addr == c_PORT_X)         w_dout = r_x;
    else if (bus.pico_addr == c_PORT_Y)    w_dout = r_y;
    else if (bus.pico_addr == c_PORT_DATA) w_dout = r_rdata;
    else if (bus.pico_addr == c_PORT_CMD)  w_dout = {6'b0, w_busy, r_rd_valid};
  end

  assign bus.pico_data_out = w_dout;
  assign bus.vga_out       = r_vga;
  assign bus.busy          = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Self-checking bench for vram_arbiter (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vram_arbiter_if bus ();

  vram_arbiter #(.COLS(40), .ROWS(30), .BASE_PORT(8'hF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  bit         alt    = 1'b0;
  string      sb_name[$];
  logic [7:0] sb_val[$];

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [0:13];

  task automatic tick();
    @(posedge clk);
    #1;
    if (alt) bus.ptick = ~bus.ptick;
  endtask

  task automatic push(input string n, input logic [7:0] v);
    sb_name.push_back(n);
    sb_val.push_back(v);
  endtask

  task automatic check(input logic [7:0] act);
    string      n;
    logic [7:0] v;
    checks++;
    if (sb_val.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      n = sb_name.pop_front();
      v = sb_val.pop_front();
      if (act !== v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, v);
      end
    end
  endtask

  task automatic peek(input string n, input logic [7:0] e, input logic [7:0] act);
    push(n, e);
    check(act);
  endtask

  task automatic pwrite(input logic [7:0] a, input logic [7:0] d);
    bus.pico_addr         = a;
    bus.pico_data_in      = d;
    bus.pico_write_strobe = 1'b1;
    tick();
    bus.pico_write_strobe = 1'b0;
  endtask

  task automatic pread(input logic [7:0] a, input logic stb, input string n, input logic [7:0] e);
    push(n, e);
    bus.pico_addr        = a;
    bus.pico_read_strobe = stb;
    #1;
    check(bus.pico_data_out);
    tick();
    bus.pico_read_strobe = 1'b0;
  endtask

  task automatic scan(input logic [5:0] x, input logic [5:0] y, input string n, input logic [7:0] e);
    bus.x_div = x;
    bus.y_div = y;
    bus.ptick = 1'b1;
    push(n, e);
    tick();
    bus.ptick = 1'b0;
    check(bus.vga_out);
  endtask

  task automatic wait_idle(input int max, input string n, output int cyc);
    cyc = 0;
    while (bus.busy && cyc < max) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s: busy=1 after %0d cycles, expected 0", n, max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0]  = '{1'b0, 8'hF0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'hF1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'hF2, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 8'hF3, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 8'hF4, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 8'h10, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 8'hF0, 8'h05, 8'h00};
    vecs[7]  = '{1'b1, 8'hF1, 8'h02, 8'h00};
    vecs[8]  = '{1'b0, 8'hF0, 8'h00, 8'h05};
    vecs[9]  = '{1'b0, 8'hF1, 8'h00, 8'h02};
    vecs[10] = '{1'b1, 8'hF0, 8'h27, 8'h00};
    vecs[11] = '{1'b0, 8'hF0, 8'h00, 8'h27};
    vecs[12] = '{1'b1, 8'hF0, 8'h05, 8'h00};
    vecs[13] = '{1'b0, 8'hF3, 8'h00, 8'h00};

    bus.ptick = 1'b0; bus.x_div = '0; bus.y_div = '0;
    bus.pico_addr = '0; bus.pico_data_in = '0;
    bus.pico_write_strobe = 1'b0; bus.pico_read_strobe = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    peek("reset_busy", 8'h00, {7'b0, bus.busy});
    peek("reset_vga", 8'h00, bus.vga_out);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) pwrite(vecs[i].addr, vecs[i].data);
      else            pread(vecs[i].addr, 1'b1, $sformatf("vec%0d", i), vecs[i].exp);
    end

    // write held off while every cycle is a scan slot
    bus.ptick = 1'b1;
    pwrite(8'hF2, 8'hE0);
    peek("wr_busy_capture", 8'h01, {7'b0, bus.busy});
    pread(8'hF3, 1'b0, "wr_stat_busy", 8'h02);
    tick(); tick();
    pwrite(8'hF2, 8'h77);
    pwrite(8'hF0, 8'h07);
    peek("wr_busy_held", 8'h01, {7'b0, bus.busy});
    bus.ptick = 1'b0;
    wait_idle(10, "wr_done", cyc);
    pread(8'hF0, 1'b0, "x_during_busy", 8'h07);
    pwrite(8'hF0, 8'h05);

    scan(6'd5, 6'd2, "scan_52", 8'hE0);
    tick();
    peek("scan_hold", 8'hE0, bus.vga_out);
    scan(6'd45, 6'd2, "scan_oor_x", 8'h00);
    scan(6'd5, 6'd31, "scan_oor_y", 8'h00);
    scan(6'd5, 6'd2, "scan_52_again", 8'hE0);

    // minimum read latency with free cycles available
    pwrite(8'hF3, 8'h00);
    pread(8'hF3, 1'b0, "rd_lat_rd", 8'h02);
    pread(8'hF3, 1'b0, "rd_lat_rdlat", 8'h02);
    pread(8'hF3, 1'b0, "rd_lat_valid", 8'h01);
    pread(8'hF2, 1'b1, "rd_data", 8'hE0);
    pread(8'hF3, 1'b0, "rd_valid_clr", 8'h00);

    alt = 1'b1;
    pwrite(8'hF3, 8'h00);
    bus.pico_addr = 8'hF3;
    cyc = 1;
    #1;
    while (!bus.pico_data_out[0] && cyc < 8) begin
      tick();
      cyc++;
      #1;
    end
    peek("rd_alt_within4", 8'h01, {7'b0, (cyc <= 4)});
    pread(8'hF2, 1'b1, "rd_alt_data", 8'hE0);
    alt = 1'b0;
    bus.ptick = 1'b0;

    pwrite(8'hF0, 8'h00);
    pwrite(8'hF1, 8'h01);
    pwrite(8'hF2, 8'h3C);
    wait_idle(4, "wr_01", cyc);
    pwrite(8'hF0, 8'd40);
    pwrite(8'hF1, 8'h00);
    pwrite(8'hF2, 8'h99);
    wait_idle(4, "wr_oor_done", cyc);
    scan(6'd0, 6'd1, "oor_wr_no_alias", 8'h3C);
    pwrite(8'hF3, 8'h00);
    pread(8'hF3, 1'b0, "oor_rd_busy0", 8'h02);
    pread(8'hF3, 1'b0, "oor_rd_busy1", 8'h02);
    pread(8'hF3, 1'b0, "oor_rd_valid", 8'h01);
    pread(8'hF2, 1'b0, "oor_rdata", 8'h00);
    pwrite(8'hF2, 8'h55);
    pread(8'hF3, 1'b0, "newreq_clr_valid", 8'h02);
    wait_idle(4, "oor_wr2_done", cyc);
    pread(8'hF3, 1'b0, "stat_idle", 8'h00);

    // reset while a write is still waiting for a free cycle
    pwrite(8'hF0, 8'h05);
    pwrite(8'hF1, 8'h02);
    bus.ptick = 1'b1;
    pwrite(8'hF2, 8'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ptick = 1'b0;
    peek("rst_mid_busy", 8'h00, {7'b0, bus.busy});
    pread(8'hF0, 1'b0, "rst_mid_x", 8'h00);
    tick(); tick();
    scan(6'd5, 6'd2, "rst_write_lost", 8'hE0);

`ifdef VRAM_FILL_EN
    alt = 1'b1;
    pwrite(8'hF4, 8'h1C);
    wait_idle(6000, "fill_done", cyc);
    peek("fill_duration", 8'h01, {7'b0, (cyc >= 2380 && cyc <= 2420)});
    alt = 1'b0;
    bus.ptick = 1'b0;
    scan(6'd0, 6'd0, "fill_first", 8'h1C);
    scan(6'd39, 6'd29, "fill_last", 8'h1C);
`else
    pwrite(8'hF4, 8'h1C);
    peek("fill_unmapped_busy", 8'h00, {7'b0, bus.busy});
    pread(8'hF4, 1'b0, "fill_unmapped_read", 8'h00);
    pread(8'hF3, 1'b0, "fill_unmapped_stat", 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
